// File: rtl/quad_gen_pkg.sv
// quad_gen_pkg: FSM states, {A,B} phase type and Gray-step helpers for the quadrature generator
package quad_gen_pkg;
   typedef enum logic {IDLE, RUN} state_e;
   typedef logic [1:0] phase_t;
   localparam phase_t PH_00 = 2'b00;
   localparam phase_t PH_10 = 2'b10;
   localparam phase_t PH_11 = 2'b11;
   localparam phase_t PH_01 = 2'b01;
   function automatic phase_t next_cw(input phase_t ph);
      return ph == PH_00 ? PH_10 : ph == PH_10 ? PH_11 : ph == PH_11 ? PH_01 : PH_00;
   endfunction
   function automatic phase_t next_ccw(input phase_t ph);
      return ph == PH_00 ? PH_01 : ph == PH_01 ? PH_11 : ph == PH_11 ? PH_10 : PH_00;
   endfunction
endpackage

// File: rtl/quad_phase_timer.sv
// quad_phase_timer: QUARTER_CYCLES prescaler; tick_o pulses on the last cycle of each quarter-phase
module quad_phase_timer #(
   parameter int QUARTER_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);
   localparam int TW = QUARTER_CYCLES > 1 ? $clog2(QUARTER_CYCLES) : 1;
   logic [TW-1:0] cnt_q;
   assign tick_o = en_i && cnt_q == TW'(QUARTER_CYCLES - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else if (clr_i || tick_o) cnt_q <= '0;
      else if (en_i) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/quadrature_signal_generator.sv
// quadrature_signal_generator: emits one Gray cycle on A/B per commanded detent and mirrors the decoder count.
// Optional index pulse on pos reaching 0 when QUAD_GEN_INDEX_EN is defined.
module quadrature_signal_generator
   import quad_gen_pkg::*;
#(
   parameter int QUARTER_CYCLES = 4,
   parameter int CNT_W = 8,
   parameter int POS_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             abort,
   output logic             phase_a,
   output logic             phase_b,
   output logic [POS_W-1:0] pos,
   output logic             busy,
   output logic             done,
   output logic             index
);
   state_e           state_q;
   phase_t           phase_q, phase_d;
   logic             dir_q, abort_q, done_q, tick, a_rise, detent_end;
   logic [CNT_W-1:0] cnt_q;
   logic [POS_W-1:0] pos_q, pos_d;

   quad_phase_timer #(.QUARTER_CYCLES(QUARTER_CYCLES)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (state_q == RUN),
      .clr_i  (state_q == IDLE),
      .tick_o (tick)
   );

   // pos moves with A's rising edge, which is where the decoder samples B
   assign phase_d    = dir_q ? next_ccw(phase_q) : next_cw(phase_q);
   assign a_rise     = tick && phase_d[1] && !phase_q[1];
   assign pos_d      = a_rise ? (dir_q ? pos_q - 1'b1 : pos_q + 1'b1) : pos_q;
   assign detent_end = tick && phase_d == PH_00;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         phase_q <= PH_00;
         dir_q   <= 1'b0;
         abort_q <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         pos_q   <= '0;
      end else begin
         pos_q  <= pos_d;
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            abort_q <= 1'b0;
            if (cmd_valid) begin
               dir_q  <= cmd_dir;
               cnt_q  <= cmd_count;
               done_q <= cmd_count == '0;
               if (cmd_count != '0) state_q <= RUN;
            end
         end else begin
            if (tick) phase_q <= phase_d;
            if (abort) abort_q <= 1'b1;
            if (detent_end) begin
               cnt_q   <= cnt_q - 1'b1;
               abort_q <= 1'b0;
               if (cnt_q == CNT_W'(1) || abort_q || abort) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
         end
      end

   assign cmd_ready = state_q == IDLE;
   assign busy      = state_q == RUN;
   assign done      = done_q;
   assign phase_a   = phase_q[1];
   assign phase_b   = phase_q[0];
   assign pos       = pos_q;

`ifdef QUAD_GEN_INDEX_EN
   localparam int IW = $clog2(QUARTER_CYCLES + 1);
   logic [IW-1:0] idx_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) idx_q <= '0;
      else if (a_rise && pos_d == '0) idx_q <= IW'(QUARTER_CYCLES);
      else if (idx_q != '0) idx_q <= idx_q - 1'b1;
   assign index = idx_q != '0;
`else
   assign index = 1'b0;
`endif
endmodule

// File: tb/tb_quadrature_signal_generator.sv
// tb_quadrature_signal_generator: command table plus random commands against a time-based waveform model.
module tb_quadrature_signal_generator;
   localparam int Q = 4;
   logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
   logic [7:0] cmd_count = '0;
   logic cmd_ready, phase_a, phase_b, busy, done, index;
   logic [7:0] pos;
   int checks = 0, errors = 0;
   logic [7:0] model_pos = '0;
   logic [1:0] cw_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   logic [1:0] ccw_seq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   logic [13:0] idle_vec;

   typedef struct {
      logic dir;
      int   n;
      int   abort_at;
      bit   spam;
      int   rst_at;
      int   exp_pos;
   } vec_t;
   vec_t vecs[10];

   quadrature_signal_generator #(.QUARTER_CYCLES(Q), .CNT_W(8), .POS_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_count(cmd_count), .abort(abort),
      .phase_a(phase_a), .phase_b(phase_b), .pos(pos), .busy(busy),
      .done(done), .index(index)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int t, input logic [13:0] got, input logic [13:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got ab=%b busy=%b done=%b rdy=%b idx=%b pos=%0d expected ab=%b busy=%b done=%b rdy=%b idx=%b pos=%0d",
                  name, t, got[13:12], got[11], got[10], got[9], got[8], got[7:0],
                  exp[13:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   // Called at a negedge; handshake happens on the following posedge (cycle 0).
   task automatic run_cmd(input logic dir, input int n, input int abort_at, input bit spam, input int rst_at);
      int nd, e, step, rises, zero_t;
      logic [1:0] ph;
      logic [7:0] p0, ep, prev;
      logic idx;
      nd = (abort_at > 0 && (abort_at + 4*Q - 1) / (4*Q) < n) ? (abort_at + 4*Q - 1) / (4*Q) : n;
      e = 4 * Q * nd;
      p0 = model_pos;
      prev = p0;
      zero_t = -1000;
      cmd_valid = 1'b1; cmd_dir = dir; cmd_count = 8'(n);
      @(posedge clk);
      #1 cmd_valid = 1'b0; cmd_dir = 1'($urandom); cmd_count = 8'($urandom);
      for (int t = 0; t <= e; t++) begin
         @(negedge clk);
         step = t / Q;
         ph = (t == e) ? 2'b00 : dir ? ccw_seq[step % 4] : cw_seq[step % 4];
         rises = dir ? (step + 2) / 4 : (step + 3) / 4;
         ep = dir ? p0 - 8'(rises) : p0 + 8'(rises);
         if (ep != prev && ep == 8'd0) zero_t = t;
         prev = ep;
`ifdef QUAD_GEN_INDEX_EN
         idx = (t - zero_t) < Q;
`else
         idx = 1'b0;
`endif
         check("cycle", t, {phase_a, phase_b, busy, done, cmd_ready, index, pos},
               {ph, t < e, t == e, t == e, idx, ep});
         model_pos = ep;
         if (t == rst_at) begin
            #1 rst_n = 1'b0;
            #1 check("async_reset", t, {phase_a, phase_b, busy, done, cmd_ready, index, pos}, idle_vec);
            repeat (2) @(negedge clk);
            check("held_reset", t, {phase_a, phase_b, busy, done, cmd_ready, index, pos}, idle_vec);
            rst_n = 1'b1;
            abort = 1'b0;
            cmd_valid = 1'b0;
            model_pos = '0;
            return;
         end
         abort = (t + 1 == abort_at);
         cmd_valid = spam && t >= 1 && t <= 4;
      end
      abort = 1'b0;
      cmd_valid = 1'b0;
   endtask

   initial begin
      idle_vec = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[0] = '{1'b0,  3,  0, 1'b0, -1,   3};
      vecs[1] = '{1'b1,  2,  0, 1'b0, -1,   1};
      vecs[2] = '{1'b1,  2,  0, 1'b0, -1, 255};
      vecs[3] = '{1'b0,  0,  0, 1'b0, -1, 255};
      vecs[4] = '{1'b0,  1,  0, 1'b0, -1,   0};
      vecs[5] = '{1'b0, 10, 21, 1'b0, -1,   2};
      vecs[6] = '{1'b0,  2,  0, 1'b1, -1,   4};
      vecs[7] = '{1'b1,  1,  0, 1'b1, -1,   3};
      vecs[8] = '{1'b0,  2,  0, 1'b0,  7,   0};
      vecs[9] = '{1'b0,  1,  0, 1'b0, -1,   1};
      repeat (2) @(negedge clk);
      check("reset_state", 0, {phase_a, phase_b, busy, done, cmd_ready, index, pos}, idle_vec);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         run_cmd(vecs[i].dir, vecs[i].n, vecs[i].abort_at, vecs[i].spam, vecs[i].rst_at);
         checks++;
         if (pos !== 8'(vecs[i].exp_pos)) begin
            errors++;
            $display("FAIL table_pos[%0d] got pos=%0d expected pos=%0d", i, pos, vecs[i].exp_pos);
         end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      check("idle_abort", 0, {phase_a, phase_b, busy, done, cmd_ready, index, pos},
            {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, model_pos});
      for (int i = 0; i < 25; i++) begin
         logic d;
         int n, ab;
         bit sp;
         d = 1'($urandom_range(0, 1));
         n = $urandom_range(0, 3);
         ab = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 4*Q*n) : 0;
         if (ab > 0 && ab % (4*Q) == 0) ab++;
         sp = n > 0 && $urandom_range(0, 1) == 1;
         run_cmd(d, n, ab, sp, -1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
